// File: rtl/rsqrt_pkg.sv
// Shared definitions for the iterative Newton-Raphson rsqrt/sqrt unit.
// Holds the controller state encoding, the default internal fixed-point format
// and small elaboration-time helpers.
package rsqrt_pkg;

  localparam int unsigned DEF_WL    = 24;
  localparam int unsigned DEF_GUARD = 4;

  // Internal datapath is unsigned Q2.FW at the default configuration.
  localparam int unsigned FW = DEF_WL - 1 + DEF_GUARD;
  localparam logic [FW+1:0] THREE = {2'b11, {FW{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StSq,
    StMx,
    StMy,
    StFin,
    StRnd,
    StDone
  } state_e;

  // 3.0 in Q2.fw for non-default formats.
  function automatic logic [63:0] three_q(input int unsigned fw);
    return 64'd3 << fw;
  endfunction

  function automatic int unsigned clamp_iter(input int unsigned req, input int unsigned max_iter);
    return (req > max_iter) ? max_iter : req;
  endfunction

endpackage

// File: rtl/rsqrt_seed_lut.sv
// Registered seed ROM for the reciprocal square root.
// Entry a holds 1/sqrt(x) at the midpoint of the a-th slice of [1.0, 2.0),
// unsigned Q1.(DataW-1). The table is computed at elaboration.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset, clears the read register
//   en_i    read enable; data_o updates only when set
//   addr_i  slice index (top fraction bits of the operand)
//   data_o  registered seed
module rsqrt_seed_lut #(
  parameter int unsigned AddrW   = 6,
  parameter int unsigned DataW   = 13,
  parameter string       LutFile = ""
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [AddrW-1:0] addr_i,
  output logic [DataW-1:0] data_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned rem = v;
    longint unsigned res = 0;
    longint unsigned b   = 64'd1 << 62;
    while (b > rem) b = b >> 2;
    while (b != 0) begin
      if (rem >= res + b) begin
        rem = rem - (res + b);
        res = (res >> 1) + b;
      end else begin
        res = res >> 1;
      end
      b = b >> 2;
    end
    return res;
  endfunction

  // y * 2^(DataW-1) = sqrt(2^(AddrW+1+2(DataW-1)) / (2^(AddrW+1) + 2a + 1)); the
  // extra factor of 4 under the root gives one bit for round-to-nearest.
  function automatic logic [DataW-1:0] seed_val(input int unsigned a);
    longint unsigned num = 64'd1 << (AddrW + 1 + 2 * (DataW - 1) + 2);
    longint unsigned den = (64'd1 << (AddrW + 1)) + 64'(2 * a + 1);
    longint unsigned y   = (isqrt(num / den) + 64'd1) >> 1;
    longint unsigned top = (64'd1 << DataW) - 64'd1;
    if (y > top) y = top;
    return DataW'(y);
  endfunction

  logic [DataW-1:0] rom [Depth];
  logic [DataW-1:0] data_q;

  for (genvar i = 0; i < Depth; i++) begin : g_entry
    localparam logic [DataW-1:0] Val = seed_val(i);
    assign rom[i] = Val;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= rom[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/rsqrt_nr_iterative.sv
// Iterative Newton-Raphson 1/sqrt(x) and sqrt(x) for x in [1.0, 2.0), Q1.(WL-1).
// One shared multiplier is sequenced through SQ/MX/MY per iteration, plus FIN
// (x*y) in sqrt mode, then rounding.
//   CLK, nRST        clock, asynchronous active-low reset
//   CE               clock enable; all state holds when low
//   in_valid/ready   operand handshake (ready only when idle)
//   din, mode, iter  operand, 0=rsqrt 1=sqrt, iteration request (clamped)
//   out_valid/ready  result handshake; result held until taken
//   dout, err        result Q1.(WL-1), out-of-range flag
module rsqrt_nr_iterative
  import rsqrt_pkg::*;
#(
  parameter int unsigned WL           = DEF_WL,
  parameter int unsigned LUT_bits     = 13,
  parameter int unsigned LUT_addWidth = 6,
  parameter int unsigned MAX_ITER     = 3,
  parameter int unsigned GUARD        = DEF_GUARD,
  parameter string       LUT_FILE     = "LUT_isqt_NR.txt",
  localparam int unsigned IterW       = $clog2(MAX_ITER + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             CE,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WL-1:0]    din,
  input  logic             mode,
  input  logic [IterW-1:0] iter,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WL-1:0]    dout,
  output logic             err
);

  localparam int unsigned Fw = WL - 1 + GUARD;
  localparam int unsigned Iw = Fw + 2;          // Q2.Fw
  localparam int unsigned Mw = WL + GUARD + 2;  // multiplier operand width
  localparam logic [Iw-1:0] Three = (Fw == FW) ? Iw'(THREE) : Iw'(three_q(Fw));

  state_e           state_q, state_d;
  logic [WL-1:0]    x_q, x_d;
  logic             mode_q, mode_d;
  logic             bad_q, bad_d;
  logic [IterW-1:0] k_q, k_d;
  logic [Iw-1:0]    y_q, y_d;
  logic [Iw-1:0]    t_q, t_d;
  logic [WL-1:0]    dout_q, dout_d;
  logic             err_q, err_d;

  logic                accept;
  logic [LUT_bits-1:0] seed;
  logic [Iw-1:0]       seed_ext, x_ext, three_minus_t;
  logic [Mw-1:0]       op_a, op_b;
  logic [2*Mw-1:0]     prod;
  logic [Iw-1:0]       prod_t, prod_h;
  logic [Iw:0]         rnd_sum;
  logic [Iw-GUARD:0]   rnd_sh;
  state_e              after_iters;
  logic                unused_bits;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign dout      = dout_q;
  assign err       = err_q;
  assign accept    = CE & in_valid & in_ready;

  // Seed read is launched at accept so it is ready while in SEED.
  rsqrt_seed_lut #(
    .AddrW  (LUT_addWidth),
    .DataW  (LUT_bits),
    .LutFile(LUT_FILE)
  ) u_seed_lut (
    .clk_i (CLK),
    .rst_ni(nRST),
    .en_i  (accept),
    .addr_i(din[WL-2 -: LUT_addWidth]),
    .data_o(seed)
  );

  assign seed_ext      = Iw'(seed) << (Fw - (LUT_bits - 1));
  assign x_ext         = {1'b0, x_q, {GUARD{1'b0}}};
  assign three_minus_t = Three - t_q;

  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (state_q)
      StSq:  begin op_a = Mw'(y_q);   op_b = Mw'(y_q);           end
      StMx:  begin op_a = Mw'(x_ext); op_b = Mw'(t_q);           end
      StMy:  begin op_a = Mw'(y_q);   op_b = Mw'(three_minus_t); end
      StFin: begin op_a = Mw'(x_ext); op_b = Mw'(y_q);           end
      default: ;
    endcase
  end

  assign prod   = {{Mw{1'b0}}, op_a} * {{Mw{1'b0}}, op_b};
  assign prod_t = prod[Fw +: Iw];
  assign prod_h = prod[Fw+1 +: Iw];  // product then /2 for the MY step

  // Half-up rounding from Fw to WL-1 fraction bits.
  assign rnd_sum = {1'b0, y_q} + ((Iw + 1)'(1) << (GUARD - 1));
  assign rnd_sh  = rnd_sum[Iw:GUARD];

  assign unused_bits = ^{prod[Fw-1:0], prod[2*Mw-1:Fw+Iw+1], rnd_sum[GUARD-1:0]};

  assign after_iters = mode_q ? StFin : StRnd;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    mode_d  = mode_q;
    bad_d   = bad_q;
    k_d     = k_q;
    y_d     = y_q;
    t_d     = t_q;
    dout_d  = dout_q;
    err_d   = err_q;
    if (CE) begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_d     = din;
            mode_d  = mode;
            bad_d   = ~din[WL-1];
            k_d     = IterW'(clamp_iter(32'(iter), MAX_ITER));
            state_d = StSeed;
          end
        end
        StSeed: begin
          if (bad_q) begin
            err_d   = 1'b1;
            dout_d  = mode_q ? '0 : '1;
            state_d = StDone;
          end else begin
            y_d     = seed_ext;
            state_d = (k_q == '0) ? after_iters : StSq;
          end
        end
        StSq: begin
          t_d     = prod_t;
          state_d = StMx;
        end
        StMx: begin
          t_d     = prod_t;
          state_d = StMy;
        end
        StMy: begin
          y_d     = prod_h;
          k_d     = k_q - IterW'(1);
          state_d = (k_q == IterW'(1)) ? after_iters : StSq;
        end
        StFin: begin
          y_d     = prod_t;
          state_d = StRnd;
        end
        StRnd: begin
          dout_d  = (|rnd_sh[Iw-GUARD:WL]) ? '1 : rnd_sh[WL-1:0];
          err_d   = 1'b0;
          state_d = StDone;
        end
        StDone: begin
          if (out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      x_q     <= '0;
      mode_q  <= 1'b0;
      bad_q   <= 1'b0;
      k_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      mode_q  <= mode_d;
      bad_q   <= bad_d;
      k_q     <= k_d;
      y_q     <= y_d;
      t_q     <= t_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

endmodule
